// File: rtl/pucch_req_scheduler_if.sv
// rtl/pucch_req_scheduler_if.sv - requester, generator and tag signals of pucch_req_scheduler
// PUCCH_SCHED_STATS_EN adds the statistics counter outputs.
interface pucch_req_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CFG_W   = 24
);
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ*CFG_W-1:0] i_req_cfg;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ-1:0]       o_req_done;
  logic                     o_err;
  logic                     o_pucch_start;
  logic                     o_pucch_rst;
  logic [CFG_W-1:0]         o_pucch_cfg;
  logic                     i_pucch_valid;
  logic                     i_pucch_done;
  logic                     o_tag_valid;
  logic [2:0]               o_tag_id;
  logic [3:0]               o_tag_sym;
  logic [3:0]               o_tag_sc;
  logic                     o_busy;
`ifdef PUCCH_SCHED_STATS_EN
  logic [15:0]              o_stat_done_cnt;
  logic [15:0]              o_stat_err_cnt;

  modport master (
    input  i_req_valid, i_req_cfg, i_pucch_valid, i_pucch_done,
    output o_req_ready, o_req_done, o_err, o_pucch_start, o_pucch_rst, o_pucch_cfg,
    output o_tag_valid, o_tag_id, o_tag_sym, o_tag_sc, o_busy,
    output o_stat_done_cnt, o_stat_err_cnt
  );

  modport slave (
    output i_req_valid, i_req_cfg, i_pucch_valid, i_pucch_done,
    input  o_req_ready, o_req_done, o_err, o_pucch_start, o_pucch_rst, o_pucch_cfg,
    input  o_tag_valid, o_tag_id, o_tag_sym, o_tag_sc, o_busy,
    input  o_stat_done_cnt, o_stat_err_cnt
  );
`else
  modport master (
    input  i_req_valid, i_req_cfg, i_pucch_valid, i_pucch_done,
    output o_req_ready, o_req_done, o_err, o_pucch_start, o_pucch_rst, o_pucch_cfg,
    output o_tag_valid, o_tag_id, o_tag_sym, o_tag_sc, o_busy
  );

  modport slave (
    output i_req_valid, i_req_cfg, i_pucch_valid, i_pucch_done,
    input  o_req_ready, o_req_done, o_err, o_pucch_start, o_pucch_rst, o_pucch_cfg,
    input  o_tag_valid, o_tag_id, o_tag_sym, o_tag_sc, o_busy
  );
`endif
endinterface

// File: rtl/pucch_req_scheduler.sv
// rtl/pucch_req_scheduler.sv - round-robin sharing of one PUCCH format 0/1 generator
// Define PUCCH_SCHED_STATS_EN to add saturating done/error counters.
module pucch_req_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int CFG_W          = 24,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  pucch_req_scheduler_if.master bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       id_q, id_d, rr_q, rr_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [3:0]       sc_cnt_q, sc_cnt_d;
  logic [7:0]       sym_cnt_q, sym_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;

  logic [3:0]         idx;
  logic [2:0]         pick_id;
  logic               pick_found;
  logic               timer_hit;
  logic [NUM_REQ-1:0] id_onehot;
  logic [2:0]         fmt;
  logic [3:0]         sym_start, n_sym;
  logic [1:0]         len_ack;
  logic               sr, len_sr, empty_req, count_ok;
  logic [7:0]         exp_sym;

  assign fmt       = cfg_q[CFG_W-1 -: 3];
  assign sym_start = cfg_q[CFG_W-4 -: 4];
  assign n_sym     = cfg_q[CFG_W-8 -: 4];
  assign len_ack   = cfg_q[CFG_W-14 -: 2];
  assign sr        = cfg_q[CFG_W-16];
  assign len_sr    = cfg_q[CFG_W-17];

  assign timer_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign id_onehot = NUM_REQ'(1) << id_q;

  // Expected count kept as whole symbols: a correct run always ends on a symbol boundary.
  assign empty_req = (len_ack == 2'd0) && (!len_sr || !sr);
  assign exp_sym   = empty_req     ? 8'd0 :
                     (fmt == 3'd1) ? {5'd0, n_sym[3:1]} : {4'd0, n_sym};
  assign count_ok  = (sym_cnt_q == exp_sym) && (sc_cnt_q == 4'd0);

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + 4'(i);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!pick_found && bus.i_req_valid[idx[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_found) state_d = S_GRANT;
      S_GRANT: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (bus.i_pucch_done || timer_hit) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    id_d      = id_q;
    rr_d      = rr_q;
    cfg_d     = cfg_q;
    sc_cnt_d  = sc_cnt_q;
    sym_cnt_d = sym_cnt_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (pick_found) id_d = pick_id;
      S_GRANT: begin
        cfg_d     = bus.i_req_cfg[id_q*CFG_W +: CFG_W];
        sc_cnt_d  = '0;
        sym_cnt_d = '0;
        timer_d   = '0;
        timeout_d = 1'b0;
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (bus.i_pucch_valid) begin
          if (sc_cnt_q == 4'd11) begin
            sc_cnt_d  = '0;
            sym_cnt_d = sym_cnt_q + 8'd1;
          end else begin
            sc_cnt_d = sc_cnt_q + 4'd1;
          end
        end
        // A done arriving on the last allowed cycle is a normal completion.
        if (timer_hit && !bus.i_pucch_done) timeout_d = 1'b1;
      end
      S_FLUSH: rr_d = (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      rr_q      <= '0;
      cfg_q     <= '0;
      sc_cnt_q  <= '0;
      sym_cnt_q <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      id_q      <= id_d;
      rr_q      <= rr_d;
      cfg_q     <= cfg_d;
      sc_cnt_q  <= sc_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus.o_req_ready   = '0;
    bus.o_req_done    = '0;
    bus.o_err         = 1'b0;
    bus.o_pucch_start = 1'b0;
    bus.o_pucch_rst   = 1'b0;
    bus.o_tag_valid   = 1'b0;
    bus.o_busy        = (state_q != S_IDLE);
    case (state_q)
      S_GRANT: bus.o_req_ready   = id_onehot;
      S_START: bus.o_pucch_start = 1'b1;
      S_RUN:   bus.o_tag_valid   = bus.i_pucch_valid;
      S_FLUSH: begin
        bus.o_req_done  = id_onehot;
        bus.o_pucch_rst = 1'b1;
        bus.o_err       = timeout_q || !count_ok;
      end
      default: ;
    endcase
  end

  assign bus.o_pucch_cfg = cfg_q;
  assign bus.o_tag_id    = id_q;
  assign bus.o_tag_sc    = sc_cnt_q;
  assign bus.o_tag_sym   = (fmt == 3'd1) ? sym_start + {sym_cnt_q[2:0], 1'b1}
                                         : sym_start + sym_cnt_q[3:0];

`ifdef PUCCH_SCHED_STATS_EN
  logic [15:0] stat_done_q, stat_done_d, stat_err_q, stat_err_d;

  always_comb begin
    stat_done_d = stat_done_q;
    stat_err_d  = stat_err_q;
    if (state_q == S_FLUSH && stat_done_q != 16'hFFFF) stat_done_d = stat_done_q + 16'd1;
    if (bus.o_err && stat_err_q != 16'hFFFF)           stat_err_d  = stat_err_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign bus.o_stat_done_cnt = stat_done_q;
  assign bus.o_stat_err_cnt  = stat_err_q;
`endif
endmodule

// File: tb/tb_pucch_req_scheduler.sv
// tb/tb_pucch_req_scheduler.sv - randomized self-checking bench for pucch_req_scheduler
module tb_pucch_req_scheduler;
  localparam int NR = 4;
  localparam int CW = 24;
  localparam int TO = 250;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pucch_req_scheduler_if #(.NUM_REQ(NR), .CFG_W(CW)) bus ();

  pucch_req_scheduler #(.NUM_REQ(NR), .CFG_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rr_m;
  logic [CW-1:0] cfgs [NR];

  int gen_nsamp, gen_left, gen_gaps;
  bit gen_hang, gen_active;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cfg(input int fmt, ss, ns, ack, lack, sr, lsr);
    return {3'(fmt), 4'(ss), 4'(ns), 2'(ack), 2'(lack), 1'(sr), 1'(lsr), 4'($urandom), 3'($urandom)};
  endfunction

  task automatic set_cfg(input int k, input logic [CW-1:0] c);
    cfgs[k] = c;
    bus.i_req_cfg[k*CW +: CW] = c;
  endtask

  function automatic int exp_count(input logic [CW-1:0] c);
    int fmt = int'(c[23:21]);
    int ns  = int'(c[16:13]);
    if (c[10:9] == 2'd0 && (c[7] == 1'b0 || c[8] == 1'b0)) return 0;
    if (fmt == 1) return 12 * (ns / 2);
    return 12 * ns;
  endfunction

  function automatic logic [3:0] exp_sym(input logic [CW-1:0] c, input int k);
    int s  = k / 12;
    int ss = int'(c[20:17]);
    if (c[23:21] == 3'd1) return 4'((ss + 2 * s + 1) % 16);
    return 4'((ss + s) % 16);
  endfunction

  function automatic int pick(input logic [NR-1:0] m, input int rr);
    for (int i = 0; i < NR; i++) if (m[(rr + i) % NR]) return (rr + i) % NR;
    return 0;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.o_req_ready, bus.o_req_done, bus.o_err, bus.o_pucch_start, bus.o_pucch_rst,
                bus.o_pucch_cfg, bus.o_tag_valid, bus.o_tag_id, bus.o_tag_sym, bus.o_tag_sc, bus.o_busy});
  endfunction

  // Generator model: gaps drawn from a bounded budget so a normal run never reaches TO.
  initial begin
    bus.i_pucch_valid = 1'b0;
    bus.i_pucch_done  = 1'b0;
    gen_active = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || bus.o_pucch_rst) begin
        gen_active = 1'b0;
        bus.i_pucch_valid = 1'b0;
        bus.i_pucch_done  = 1'b0;
      end else if (bus.o_pucch_start) begin
        gen_active = 1'b1;
        gen_left   = gen_nsamp;
        gen_gaps   = $urandom_range(0, 30);
        bus.i_pucch_valid = 1'b0;
      end else if (gen_active) begin
        if (gen_left > 0) begin
          if (gen_gaps > 0 && $urandom_range(0, 3) == 0) begin
            gen_gaps--;
            bus.i_pucch_valid = 1'b0;
          end else begin
            bus.i_pucch_valid = 1'b1;
            gen_left--;
            if (gen_left == 0 && !gen_hang && $urandom_range(0, 1) == 1) bus.i_pucch_done = 1'b1;
          end
        end else begin
          bus.i_pucch_valid = 1'b0;
          if (!gen_hang) bus.i_pucch_done = 1'b1;
        end
      end
    end
  end

  task automatic txn(input string nm, input int extra, input bit hang, input bit clr);
    int id, k, cyc, nsamp;
    bit got, early_err, exp_err;
    logic [CW-1:0] c;
    id      = pick(bus.i_req_valid, rr_m);
    c       = cfgs[id];
    nsamp   = hang ? extra : exp_count(c) + extra;
    exp_err = hang || (nsamp != exp_count(c));
    gen_nsamp = nsamp;
    gen_hang  = hang;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = (bus.o_req_ready != '0);
    end
    check({nm, ".ready"}, 64'({bus.o_req_ready, bus.o_busy}), 64'({NR'(1) << id, 1'b1}));
    if (clr) bus.i_req_valid = '0;
    @(negedge clk);
    check({nm, ".start"}, 64'({bus.o_pucch_start, bus.o_req_ready, bus.o_pucch_cfg}),
          64'({1'b1, NR'(0), c}));
    k = 0; cyc = 0; got = 1'b0; early_err = 1'b0;
    while (!got && cyc < TO + 60) begin
      @(negedge clk);
      cyc++;
      if (bus.o_tag_valid) begin
        if (k < nsamp)
          check({nm, ".tag"}, 64'({bus.o_tag_id, bus.o_tag_sym, bus.o_tag_sc}),
                64'({3'(id), exp_sym(c, k), 4'(k % 12)}));
        k++;
      end
      got = (bus.o_req_done != '0);
      if (!got && bus.o_err) early_err = 1'b1;
    end
    check({nm, ".flush"}, 64'({bus.o_req_done, bus.o_pucch_rst, bus.o_err, early_err}),
          64'({NR'(1) << id, 1'b1, exp_err, 1'b0}));
    check({nm, ".nsamp"}, 64'(k), 64'(nsamp));
    if (hang) check({nm, ".timeout_cyc"}, 64'(cyc), 64'(TO + 1));
    rr_m = (id + 1) % NR;
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    rr_m = 0;
    gen_nsamp = 0;
    gen_hang  = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_cfg   = '0;
    for (int k = 0; k < NR; k++) cfgs[k] = '0;
    repeat (3) @(negedge clk);
    check("reset.outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.outs", outs(), 64'd0);

    for (int k = 0; k < NR; k++) set_cfg(k, mk_cfg(0, $urandom_range(0, 15), 1, 1, 1, 0, 0));
    bus.i_req_valid = 4'b1111;
    txn("rr0", 0, 0, 0);
    txn("rr1", 0, 0, 0);
    txn("rr2", 0, 0, 0);
    txn("rr3", 0, 0, 0);
    txn("rr4", 0, 0, 1);

    set_cfg(0, mk_cfg(0, 12, 2, 1, 1, 0, 0));
    bus.i_req_valid = 4'b0001;
    txn("single", 0, 0, 1);

    set_cfg(1, mk_cfg(1, 0, 14, 1, 1, 0, 0));
    bus.i_req_valid = 4'b0010;
    txn("fmt1", 0, 0, 1);

    set_cfg(2, mk_cfg(0, 3, 2, 1, 1, 0, 0));
    bus.i_req_valid = 4'b0100;
    gen_nsamp = 24;
    gen_hang  = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = bus.o_pucch_start;
    end
    check("rst.reach_start", 64'(got), 64'd1);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst.async_outs", outs(), 64'd0);
    bus.i_req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("rst.no_done", 64'({bus.o_req_done, bus.o_busy}), 64'd0);
    end
    bus.i_req_valid = 4'b1111;
    txn("post_rst", 0, 0, 1);

    set_cfg(3, mk_cfg(0, 5, 4, 0, 0, 0, 1));
    bus.i_req_valid = 4'b1000;
    txn("empty", 0, 0, 1);
    bus.i_req_valid = 4'b1000;
    txn("stray", 1, 0, 1);

    set_cfg(0, mk_cfg(0, 2, 2, 1, 1, 0, 0));
    bus.i_req_valid = 4'b0001;
    txn("timeout", 0, 1, 1);
    set_cfg(1, mk_cfg(2, 4, 2, 1, 1, 1, 1));
    bus.i_req_valid = 4'b0010;
    txn("fmt2", 0, 1, 1);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NR; k++)
        set_cfg(k, mk_cfg($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                          $urandom_range(0, 1)));
      bus.i_req_valid = NR'($urandom_range(1, 15));
      txn("rnd", ($urandom_range(0, 3) == 0) ? 1 : 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pucch_req_scheduler.md
Name: pucch_req_scheduler

Overview:
- Round-robin scheduler that shares one PUCCH format 0/1 sequence generator between NUM_REQ requesters (per-UE UCI sources).
- Latches the granted requester's configuration, drives the generator's start, and tags each output sample with requester ID, symbol and subcarrier.
- Detects completion and returns the generator to IDLE with a one-cycle local reset.
- Supervises with a timeout and a sample-count check.

Parameters:
- NUM_REQ, 4, number of requesters (2-8).
- CFG_W, 24, packed config width per requester. Field order MSB to LSB: format[2:0], symStart[3:0], nPUCCHSym[3:0], ack[1:0], lenACK[1:0], sr, lenSR, m0[3:0], occi[2:0].
- TIMEOUT_CYCLES, 1023, maximum RUN cycles before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req_valid  in  NUM_REQ  per-requester request pending (level)
- i_req_cfg  in  NUM_REQ*CFG_W  packed configs; requester k occupies [k*CFG_W +: CFG_W]
- o_req_ready  out  NUM_REQ  one-hot, 1-cycle pulse; config accepted
- o_req_done  out  NUM_REQ  one-hot, 1-cycle pulse; generation finished or aborted
- o_err  out  1  1-cycle pulse on timeout or sample-count mismatch
- o_pucch_start  out  1  generator start pulse
- o_pucch_rst  out  1  generator local reset pulse
- o_pucch_cfg  out  CFG_W  latched config to generator
- i_pucch_valid  in  1  generator sample valid
- i_pucch_done  in  1  generator done (level; held until generator reset)
- o_tag_valid  out  1  equals i_pucch_valid while in RUN, else 0
- o_tag_id  out  3  granted requester index
- o_tag_sym  out  4  OFDM symbol index of current sample
- o_tag_sc  out  4  subcarrier 0-11 of current sample
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, all counters 0. Reset mid-operation aborts immediately; no o_req_done is issued.
- States: IDLE, GRANT, START, RUN, FLUSH.
- IDLE: if any i_req_valid, pick the first set bit searching from rr pointer upward with wrap. Register grant id; go to GRANT.
- GRANT (1 cycle):
  - o_req_ready[id]=1.
  - Latch cfg of id into o_pucch_cfg. The latched config is held until the next GRANT.
  - Clear sample counter sc_cnt, symbol counter sym_cnt and timer.
  - Go to START.
- START (1 cycle): o_pucch_start=1; go to RUN.
- RUN:
  - Timer increments each cycle.
  - Each i_pucch_valid: sc_cnt increments; on wrap 11->0, sym_cnt increments.
  - o_tag_sc=sc_cnt.
  - Format 0: o_tag_sym = symStart+sym_cnt.
  - Format 1: o_tag_sym = symStart + 2*sym_cnt + 1.
  - All tags are 4-bit, truncated.
  - Exit to FLUSH when i_pucch_done=1, or when timer == TIMEOUT_CYCLES (abort: o_err=1 in the FLUSH cycle).
- FLUSH (1 cycle):
  - o_pucch_rst=1, o_req_done[id]=1.
  - Sample-count check. Expected total samples: 12*nPUCCHSym for format 0, 12*floor(nPUCCHSym/2) for format 1, 0 for an empty request (lenACK=0 and (lenSR=0 or sr=0)).
  - If the received count differs, o_err=1.
  - rr pointer <= id+1 mod NUM_REQ; go to IDLE.
- Throughput: minimum 4 cycles of overhead per request (IDLE, GRANT, START, FLUSH) plus the generator's run time.
- i_pucch_valid and i_pucch_done in the same cycle: the sample is counted and tagged, then the block exits to FLUSH.
- i_pucch_done in the START cycle: ignored; sampled from RUN only.
- Empty request: the generator reaches done with no valids. The block completes normally with no o_err.
- Requester deasserting i_req_valid after grant: no effect. Requester reasserting: eligible in the next IDLE.
- Formats 2-4 in cfg: granted, then terminated via timeout with o_err.

Optional Feature:
- Macro: PUCCH_SCHED_STATS_EN.
- When defined, adds outputs o_stat_done_cnt[15:0] and o_stat_err_cnt[15:0].
  - Saturating counters of FLUSH cycles and of o_err pulses.
  - Cleared by rst only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: req0 format 0, symStart=12, nPUCCHSym=2, ack=1, lenACK=1. Expect ready[0] pulse, start one cycle later, 24 tagged samples (sym 12 then 13, sc 0-11 each), then o_pucch_rst and done[0] together, no o_err.
- Round-robin: valid=4'b1111 held for 4 grants. Grant order 0,1,2,3, then 0; each ready pulse is one-hot.
- Format 1: symStart=0, nPUCCHSym=14. Expect 84 samples with o_tag_sym in 1,3,…,13 and no o_err.
- Empty request: lenACK=0, sr=0. Expect zero tag_valid, done pulse, no o_err; a generator delivering 1 stray sample must instead raise o_err.
- Timeout: generator model never asserts done, TIMEOUT_CYCLES=16. Expect FLUSH 17 cycles after START with o_err, o_pucch_rst and done[id]; the next request is served afterwards.
- Async reset asserted mid-RUN: all outputs 0 immediately, no done pulse; rr pointer restarts at 0.
